// File: rtl/sub_shift_serial_if.sv
// Handshake bundle for the SubBytes+ShiftRows stage: input state in, transformed state out.
interface sub_shift_serial_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sub_shift_serial.sv
// Byte-serial AES SubBytes+ShiftRows (or inverse when DECRYPT=1) with an arithmetic S-box.
// Define SUB_SHIFT_QUAD_LANE_EN to process one full column (four S-boxes) per cycle.
module sub_shift_serial #(
  parameter bit DECRYPT = 1'b0
) (
  input logic               clk,
  input logic               rst,
  sub_shift_serial_if.slave bus
);

`ifdef SUB_SHIFT_QUAD_LANE_EN
  localparam int unsigned LANES = 4;
`else
  localparam int unsigned LANES = 1;
`endif
  localparam logic [3:0] LAST_CNT = 4'(16 / LANES - 1);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [0:127] buf_q, buf_d;
  logic [0:127] out_q, out_d;
  logic [3:0]   src;
  logic [1:0]   dst_col;
  logic [3:0]   dst;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // a^254 == a^-1 in GF(2^8); also maps 0 to 0 without a special case.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    if (DECRYPT) begin
      t = {a[1:0], a[7:2]} ^ {a[4:0], a[7:5]} ^ {a[6:0], a[7]} ^ 8'h05;
      return gf_inv(t);
    end else begin
      t = gf_inv(a);
      return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
    end
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    out_d   = out_q;
    src     = '0;
    dst_col = '0;
    dst     = '0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          buf_d   = bus.in_data;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        // Source byte index doubles as (col,row); ShiftRows only moves the column.
        for (int unsigned l = 0; l < LANES; l++) begin
          src     = 4'(32'(cnt_q) * LANES + l);
          dst_col = DECRYPT ? (src[3:2] + src[1:0]) : (src[3:2] - src[1:0]);
          dst     = {dst_col, src[1:0]};
          out_d[{dst, 3'b000} +: 8] = sbox(buf_q[{src, 3'b000} +: 8]);
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_q;

endmodule

// File: tb/tb_sub_shift_serial.sv
// Self-checking bench for sub_shift_serial: FIPS vectors, random states vs a table-based AES model, handshake corners.
module tb_sub_shift_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sub_shift_serial_if enc_if();
  sub_shift_serial_if dec_if();

  sub_shift_serial #(.DECRYPT(1'b0)) u_enc (.clk(clk), .rst(rst), .bus(enc_if.slave));
  sub_shift_serial #(.DECRYPT(1'b1)) u_dec (.clk(clk), .rst(rst), .bus(dec_if.slave));

`ifdef SUB_SHIFT_QUAD_LANE_EN
  localparam int SUB_CYC = 4;
`else
  localparam int SUB_CYC = 16;
`endif
  localparam int XFER_PERIOD = SUB_CYC + 2;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_m  [256];
  logic [7:0] isb_m [256];

  typedef struct {
    bit           dec;
    logic [0:127] din;
    logic [0:127] exp;
  } vec_t;

  task automatic check(input string name, input logic [0:127] act, input logic [0:127] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference S-box from exp/log tables over generator 0x03 plus bitwise affine map.
  task automatic build_model();
    logic [7:0] e;
    logic [7:0] inv;
    logic [7:0] b;
    logic [7:0] c;
    int exp_t [255];
    int log_t [256];
    c = 8'h63;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = int'(e);
      log_t[e] = i;
      e = e ^ ({e[6:0], 1'b0} ^ (e[7] ? 8'h1b : 8'h00));
    end
    for (int x = 0; x < 256; x++) begin
      if (x == 0) inv = 8'h00;
      else inv = 8'(exp_t[(255 - log_t[x]) % 255]);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sb_m[x]  = b;
      isb_m[b] = 8'(x);
    end
  endtask

  function automatic logic [0:127] model(input bit dec, input logic [0:127] s);
    logic [0:127] m;
    logic [7:0]   b;
    int r, c, sc;
    m = '0;
    for (int k = 0; k < 16; k++) begin
      r  = k % 4;
      c  = k / 4;
      sc = dec ? (c + 4 - r) % 4 : (c + r) % 4;
      b  = s[8 * (4 * sc + r) +: 8];
      m[8 * k +: 8] = dec ? isb_m[b] : sb_m[b];
    end
    return m;
  endfunction

  function automatic logic [0:127] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int get_in_ready(input bit dec);
    return dec ? int'(dec_if.in_ready) : int'(enc_if.in_ready);
  endfunction

  function automatic int get_out_valid(input bit dec);
    return dec ? int'(dec_if.out_valid) : int'(enc_if.out_valid);
  endfunction

  function automatic logic [0:127] get_out_data(input bit dec);
    return dec ? dec_if.out_data : enc_if.out_data;
  endfunction

  task automatic set_in(input bit dec, input logic v, input logic [0:127] d);
    if (dec) begin
      dec_if.in_valid = v;
      dec_if.in_data  = d;
    end else begin
      enc_if.in_valid = v;
      enc_if.in_data  = d;
    end
  endtask

  task automatic set_oready(input bit dec, input logic v);
    if (dec) dec_if.out_ready = v;
    else enc_if.out_ready = v;
  endtask

  task automatic wait_out_valid(input bit dec, output int n);
    n = 0;
    while (get_out_valid(dec) == 0 && n < SUB_CYC + 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run_vec(input bit dec, input logic [0:127] din, input logic [0:127] exp, input string name);
    int n;
    n = 0;
    while (get_in_ready(dec) == 0 && n < 40) begin
      tick();
      n++;
    end
    check_i({name, " ready before accept"}, get_in_ready(dec), 1);
    set_in(dec, 1'b1, din);
    tick();
    set_in(dec, 1'b0, din);
    wait_out_valid(dec, n);
    check_i({name, " latency"}, n, SUB_CYC);
    check({name, " data"}, get_out_data(dec), exp);
    set_oready(dec, 1'b1);
    tick();
    set_oready(dec, 1'b0);
    check_i({name, " in_ready after xfer"}, get_in_ready(dec), 1);
    check_i({name, " out_valid after xfer"}, get_out_valid(dec), 0);
  endtask

  initial begin
    vec_t         tbl [5];
    logic [0:127] din;
    logic [0:127] exp;
    logic [0:127] s   [3];
    int           n, got, last_t, idx_in;
    bit           acc, xf;

    set_in(1'b0, 1'b0, '0);
    set_in(1'b1, 1'b0, '0);
    set_oready(1'b0, 1'b0);
    set_oready(1'b1, 1'b0);
    rst = 1'b1;
    build_model();

    tbl[0] = '{1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
    tbl[1] = '{1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
    tbl[2] = '{1'b0, {16{8'h00}}, {16{8'h63}}};
    tbl[3] = '{1'b0, {16{8'h53}}, {16{8'hed}}};
    tbl[4] = '{1'b0, {16{8'hff}}, {16{8'h16}}};

    tick();
    tick();
    check_i("reset in_ready", get_in_ready(1'b0), 1);
    check_i("reset out_valid", get_out_valid(1'b0), 0);
    check("reset out_data", get_out_data(1'b0), '0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++)
      run_vec(tbl[i].dec, tbl[i].din, tbl[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      din = rand_state();
      run_vec(bit'(i % 2), din, model(bit'(i % 2), din), $sformatf("rand%0d", i));
    end

    // Backpressure: hold DONE for 10 cycles with a stray in_valid pulse.
    din = rand_state();
    exp = model(1'b0, din);
    set_in(1'b0, 1'b1, din);
    tick();
    set_in(1'b0, 1'b0, din);
    wait_out_valid(1'b0, n);
    check_i("bp latency", n, SUB_CYC);
    for (int i = 0; i < 10; i++) begin
      check_i("bp out_valid", get_out_valid(1'b0), 1);
      check_i("bp in_ready", get_in_ready(1'b0), 0);
      check("bp out_data", get_out_data(1'b0), exp);
      if (i == 3) set_in(1'b0, 1'b1, rand_state());
      if (i == 4) set_in(1'b0, 1'b0, '0);
      tick();
    end
    set_oready(1'b0, 1'b1);
    tick();
    set_oready(1'b0, 1'b0);
    check_i("bp release out_valid", get_out_valid(1'b0), 0);
    check_i("bp release in_ready", get_in_ready(1'b0), 1);
    check("bp data held after xfer", get_out_data(1'b0), exp);
    for (int i = 0; i < 3; i++) tick();
    check_i("bp stray not accepted", get_in_ready(1'b0), 1);
    check_i("bp no phantom output", get_out_valid(1'b0), 0);

    // Reset in the middle of SUB discards the partial result.
    din = rand_state();
    set_in(1'b0, 1'b1, din);
    tick();
    set_in(1'b0, 1'b0, din);
    for (int i = 0; i < ((SUB_CYC > 7) ? 7 : 2); i++) tick();
    check_i("mid busy before reset", get_in_ready(1'b0), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_i("mid rst out_valid", get_out_valid(1'b0), 0);
    check_i("mid rst in_ready", get_in_ready(1'b0), 1);
    check("mid rst out_data", get_out_data(1'b0), '0);
    din = rand_state();
    run_vec(1'b0, din, model(1'b0, din), "after reset");

    // Back-to-back: three states with in_valid/out_ready held high.
    for (int i = 0; i < 3; i++) s[i] = rand_state();
    set_oready(1'b0, 1'b1);
    set_in(1'b0, 1'b1, s[0]);
    idx_in = 0;
    got    = 0;
    last_t = 0;
    for (int cyc = 0; cyc < 200 && got < 3; cyc++) begin
      acc = enc_if.in_valid && enc_if.in_ready;
      xf  = enc_if.out_valid && enc_if.out_ready;
      if (xf) begin
        check($sformatf("b2b data%0d", got), enc_if.out_data, model(1'b0, s[got]));
        if (got > 0) check_i($sformatf("b2b spacing%0d", got), cyc - last_t, XFER_PERIOD);
        last_t = cyc;
        got++;
      end
      tick();
      if (acc) begin
        idx_in++;
        if (idx_in < 3) set_in(1'b0, 1'b1, s[idx_in]);
        else set_in(1'b0, 1'b0, '0);
      end
    end
    check_i("b2b count", got, 3);
    set_oready(1'b0, 1'b0);
    set_in(1'b0, 1'b0, '0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
